// File: rtl/wb_select_stage.sv
// Registered writeback-select stage: decodes jal/rd/rt and ALU/memory/link sources
// into a register-file write, waiting a bounded number of cycles for late load data.
module wb_select_stage #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned LINK_REG    = 31,
  parameter int unsigned PC_INC      = 1,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_regwrite,
  input  logic [1:0]        in_jump,
  input  logic              in_regdst,
  input  logic              in_memtoreg,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [REG_AW-1:0] in_rt_num,
  input  logic [REG_AW-1:0] in_rd_num,
  input  logic              mem_valid,
  input  logic [DATA_W-1:0] mem_data,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_num,
  output logic [DATA_W-1:0] wb_data,
  output logic              err
);

  typedef enum logic [0:0] {IDLE, WAIT_MEM} state_e;

  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [REG_AW-1:0]   num_q, num_d;
  logic                wb_en_q, wb_en_d;
  logic [REG_AW-1:0]   wb_num_q, wb_num_d;
  logic [DATA_W-1:0]   wb_data_q, wb_data_d;
  logic                err_q, err_d;

  logic                accept;
  logic                is_jal;
  logic                is_load;
  logic [REG_AW-1:0]   dec_num;
  logic                wr_req;
  logic [REG_AW-1:0]   wr_num;
  logic [DATA_W-1:0]   wr_data;

  assign in_ready = (state_q == IDLE);
  assign accept   = in_valid && in_ready;
  assign is_jal   = (in_jump == 2'b10);
  assign is_load  = in_regwrite && in_memtoreg && !is_jal;
  assign dec_num  = is_jal ? REG_AW'(LINK_REG) : (in_regdst ? in_rd_num : in_rt_num);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d = state_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    err_d   = 1'b0;
    wr_req  = 1'b0;
    wr_num  = num_q;
    wr_data = mem_data;

    unique case (state_q)
      IDLE: begin
        if (accept && in_regwrite) begin
          wr_num = dec_num;
          if (is_load) begin
            if (mem_valid) begin
              wr_req = 1'b1;
            end else begin
              num_d   = dec_num;
              cnt_d   = '0;
              state_d = WAIT_MEM;
            end
          end else begin
            wr_req  = 1'b1;
            wr_data = is_jal ? (in_pc + DATA_W'(PC_INC)) : in_alu;
          end
        end
      end
      WAIT_MEM: begin
        // Arriving data takes precedence over a coincident timeout.
        if (mem_valid) begin
          wr_req  = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // r0 is hardwired to zero, so its writes never reach the register file;
  // number and data hold their last values whenever no write is issued.
  always_comb begin
    wb_en_d   = 1'b0;
    wb_num_d  = wb_num_q;
    wb_data_d = wb_data_q;
    if (wr_req && (wr_num != '0)) begin
      wb_en_d   = 1'b1;
      wb_num_d  = wr_num;
      wb_data_d = wr_data;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      num_q     <= '0;
      wb_en_q   <= 1'b0;
      wb_num_q  <= '0;
      wb_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      num_q     <= num_d;
      wb_en_q   <= wb_en_d;
      wb_num_q  <= wb_num_d;
      wb_data_q <= wb_data_d;
      err_q     <= err_d;
    end
  end

  assign wb_en   = wb_en_q;
  assign wb_num  = wb_num_q;
  assign wb_data = wb_data_q;
  assign err     = err_q;

endmodule

// File: tb/tb_wb_select_stage.sv
// Scoreboard bench for wb_select_stage: expected writes are queued when ops are
// driven and popped whenever the stage raises wb_en.
module tb_wb_select_stage;

  localparam int T = 15;

  typedef struct packed {
    logic [4:0]  num;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid, in_ready, in_regwrite, in_regdst, in_memtoreg;
  logic [1:0]  in_jump;
  logic [31:0] in_pc, in_alu, mem_data, wb_data;
  logic [4:0]  in_rt_num, in_rd_num, wb_num;
  logic        mem_valid, wb_en, err;

  wr_t exp_q[$];
  int  tests = 0;
  int  fails = 0;
  int  writes_seen = 0;
  int  err_seen = 0;

  always #5 clk = ~clk;

  wb_select_stage #(
    .DATA_W(32), .REG_AW(5), .LINK_REG(31), .PC_INC(1), .MEM_TIMEOUT(T)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_regwrite(in_regwrite), .in_jump(in_jump), .in_regdst(in_regdst),
    .in_memtoreg(in_memtoreg), .in_pc(in_pc), .in_alu(in_alu),
    .in_rt_num(in_rt_num), .in_rd_num(in_rd_num),
    .mem_valid(mem_valid), .mem_data(mem_data),
    .wb_en(wb_en), .wb_num(wb_num), .wb_data(wb_data), .err(err)
  );

  // Advance one clock, sample 1 ns after the edge and retire any write against the scoreboard.
  task automatic tick();
    wr_t e;
    @(posedge clk);
    #1;
    if (wb_en === 1'b1) begin
      writes_seen++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: got num=%0d data=%h, required no write", wb_num, wb_data);
      end else begin
        e = exp_q.pop_front();
        if (wb_num !== e.num || wb_data !== e.data) begin
          fails++;
          $display("FAIL wb_write: got (%0d,%h) required (%0d,%h)", wb_num, wb_data, e.num, e.data);
        end
      end
    end
    if (err === 1'b1) err_seen++;
  endtask

  task automatic drive_op(input logic regwrite, input logic [1:0] jump, input logic regdst,
                          input logic memtoreg, input logic [31:0] pc, input logic [31:0] alu,
                          input logic [4:0] rt, input logic [4:0] rd);
    in_valid    = 1'b1;
    in_regwrite = regwrite;
    in_jump     = jump;
    in_regdst   = regdst;
    in_memtoreg = memtoreg;
    in_pc       = pc;
    in_alu      = alu;
    in_rt_num   = rt;
    in_rd_num   = rd;
  endtask

  task automatic idle();
    in_valid    = 1'b0;
    in_regwrite = 1'b0;
    in_jump     = 2'b00;
    in_regdst   = 1'b0;
    in_memtoreg = 1'b0;
    in_pc       = '0;
    in_alu      = '0;
    in_rt_num   = '0;
    in_rd_num   = '0;
    mem_valid   = 1'b0;
    mem_data    = '0;
  endtask

  task automatic push(input logic [4:0] num, input logic [31:0] data);
    wr_t e;
    e.num  = num;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    idle();
    #1 rst_n = 1'b0;
    #2;
    tests++;
    if ({wb_en, wb_num, wb_data, err, in_ready} !== {1'b0, 5'd0, 32'd0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL reset_state: got en=%b num=%0d data=%h err=%b rdy=%b, required 0/0/0/0/1",
               wb_en, wb_num, wb_data, err, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_jal();
    // memtoreg/regdst set on purpose: jal must ignore them and must not wait.
    drive_op(1'b1, 2'b10, 1'b1, 1'b1, 32'h100, 32'hABCD, 5'd2, 5'd3);
    push(5'd31, 32'h101);
    tick();
    tests++;
    if (wb_en !== 1'b1 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL jal_latency: got en=%b rdy=%b, required 1/1", wb_en, in_ready);
    end
    drive_op(1'b1, 2'b10, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h1, 5'd2, 5'd3);
    push(5'd31, 32'h0);
    tick();
    tests++;
    if (wb_en !== 1'b1) begin
      fails++;
      $display("FAIL jal_wrap: got en=%b, required 1", wb_en);
    end
    idle();
    tick();
    tests++;
    if (wb_en !== 1'b0) begin
      fails++;
      $display("FAIL jal_pulse: got en=%b, required 0", wb_en);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      drive_op(1'b1, 2'b00, 1'b1, 1'b0, 32'h40, 32'(i + 1), 5'd20, 5'(8 + i));
      push(5'(8 + i), 32'(i + 1));
      tick();
      tests++;
      if (wb_en !== 1'b1) begin
        fails++;
        $display("FAIL rtype_stream_%0d: got en=%b, required 1", i, wb_en);
      end
    end
    drive_op(1'b1, 2'b00, 1'b0, 1'b0, 32'h44, 32'h7, 5'd4, 5'd13);
    push(5'd4, 32'h7);
    tick();
    tests++;
    if (wb_en !== 1'b1) begin
      fails++;
      $display("FAIL rt_dest: got en=%b, required 1", wb_en);
    end
    idle();
    tick();
  endtask

  task automatic test_delayed_load();
    drive_op(1'b1, 2'b00, 1'b0, 1'b1, 32'h0, 32'h77, 5'd5, 5'd6);
    tick();
    idle();
    tests++;
    if (in_ready !== 1'b0 || wb_en !== 1'b0) begin
      fails++;
      $display("FAIL load_wait_enter: got rdy=%b en=%b, required 0/0", in_ready, wb_en);
    end
    tick();
    tick();
    mem_valid = 1'b1;
    mem_data  = 32'hDEAD_BEEF;
    push(5'd5, 32'hDEAD_BEEF);
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL load_wait_hold: got rdy=%b, required 0", in_ready);
    end
    tick();
    mem_valid = 1'b0;
    tests++;
    if (wb_en !== 1'b1 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL load_complete: got en=%b rdy=%b, required 1/1", wb_en, in_ready);
    end
    // Same-cycle data: no wait state.
    drive_op(1'b1, 2'b00, 1'b0, 1'b1, 32'h0, 32'h99, 5'd6, 5'd7);
    mem_valid = 1'b1;
    mem_data  = 32'h1234_5678;
    push(5'd6, 32'h1234_5678);
    tick();
    idle();
    tests++;
    if (wb_en !== 1'b1 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL load_same_cycle: got en=%b rdy=%b, required 1/1", wb_en, in_ready);
    end
    tick();
  endtask

  task automatic test_timeout();
    int w0, e0, bad;
    w0 = writes_seen;
    e0 = err_seen;
    bad = 0;
    drive_op(1'b1, 2'b00, 1'b0, 1'b1, 32'h0, 32'h0, 5'd7, 5'd0);
    tick();
    idle();
    for (int k = 1; k < T; k++) begin
      tick();
      if (err !== 1'b0 || in_ready !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL timeout_early: got %0d cycles with err/ready set early, required 0", bad);
    end
    tick();
    tests++;
    if (err !== 1'b1 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL timeout_err: got err=%b rdy=%b, required 1/1", err, in_ready);
    end
    tick();
    tests++;
    if (err !== 1'b0 || writes_seen != w0 || err_seen != e0 + 1) begin
      fails++;
      $display("FAIL timeout_pulse: got err=%b writes=%0d errs=%0d, required 0/0/1",
               err, writes_seen - w0, err_seen - e0);
    end
    // Data arriving in the timeout cycle wins.
    e0 = err_seen;
    drive_op(1'b1, 2'b00, 1'b0, 1'b1, 32'h0, 32'h0, 5'd9, 5'd0);
    tick();
    idle();
    for (int k = 1; k < T; k++) tick();
    mem_valid = 1'b1;
    mem_data  = 32'hCAFE_0009;
    push(5'd9, 32'hCAFE_0009);
    tick();
    mem_valid = 1'b0;
    tests++;
    if (wb_en !== 1'b1 || err !== 1'b0 || err_seen != e0) begin
      fails++;
      $display("FAIL timeout_data_wins: got en=%b err=%b, required 1/0", wb_en, err);
    end
    tick();
  endtask

  task automatic test_r0_and_store();
    drive_op(1'b1, 2'b00, 1'b1, 1'b0, 32'h0, 32'h55, 5'd3, 5'd0);
    tick();
    idle();
    tests++;
    if ({wb_en, wb_num, wb_data} !== {1'b0, 5'd9, 32'hCAFE_0009}) begin
      fails++;
      $display("FAIL r0_suppress: got en=%b num=%0d data=%h, required 0/9/cafe0009",
               wb_en, wb_num, wb_data);
    end
    drive_op(1'b0, 2'b00, 1'b0, 1'b1, 32'h0, 32'h66, 5'd3, 5'd4);
    tick();
    idle();
    tests++;
    if (wb_en !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL store_no_write: got en=%b rdy=%b, required 0/1", wb_en, in_ready);
    end
    // Load to r0 still waits, then writes nothing.
    drive_op(1'b1, 2'b00, 1'b0, 1'b1, 32'h0, 32'h0, 5'd0, 5'd5);
    tick();
    idle();
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL r0_load_wait: got rdy=%b, required 0", in_ready);
    end
    mem_valid = 1'b1;
    mem_data  = 32'h0BAD_0000;
    tick();
    mem_valid = 1'b0;
    tests++;
    if (wb_en !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL r0_load_done: got en=%b rdy=%b, required 0/1", wb_en, in_ready);
    end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    int w0;
    drive_op(1'b1, 2'b00, 1'b0, 1'b1, 32'h0, 32'h0, 5'd11, 5'd0);
    tick();
    idle();
    tick();
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if ({wb_en, wb_num, wb_data, err, in_ready} !== {1'b0, 5'd0, 32'd0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL reset_mid_wait: got en=%b num=%0d data=%h err=%b rdy=%b, required 0/0/0/0/1",
               wb_en, wb_num, wb_data, err, in_ready);
    end
    #1 rst_n = 1'b1;
    w0 = writes_seen;
    tick();
    mem_valid = 1'b1;
    mem_data  = 32'h5757_5757;
    tick();
    mem_valid = 1'b0;
    tick();
    tests++;
    if (wb_en !== 1'b0 || writes_seen != w0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL stale_mem_valid: got en=%b writes=%0d rdy=%b, required 0/0/1",
               wb_en, writes_seen - w0, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_jal();
    test_back_to_back();
    test_delayed_load();
    test_timeout();
    test_r0_and_store();
    test_reset_mid_wait();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d writes outstanding, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_select_stage.md
# wb_select_stage

Registered writeback-select stage for the MIPS core, and the successor to the combinational writeback mux. It decodes the Jump/RegDst/MemtoReg controls into a destination register number and a write data value. It also handles loads whose data arrives from memory one or more cycles late, with a valid/ready handshake toward the upstream stage and a bounded wait timeout. It sits between the memory stage and the register file write port.

## Interface
Parameters:
- DATA_W, 32, datapath width
- REG_AW, 5, register-number width
- LINK_REG, 31, destination register for jal
- PC_INC, 1, added to PC for the link value (PC is word-addressed)
- MEM_TIMEOUT, 15, maximum cycles spent waiting for load data (≥1)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream op present
- in_ready  out  1  stage can accept an op; equals (state==IDLE)
- in_regwrite  in  1  op writes the register file
- in_jump  in  2  jump class; 2'b10 = jal
- in_regdst  in  1  1: destination is rd, 0: destination is rt
- in_memtoreg  in  1  1: data source is memory, 0: data source is ALU
- in_pc, in_alu  in  DATA_W  PC of the op and ALU result
- in_rt_num, in_rd_num  in  REG_AW  register numbers
- mem_valid  in  1  load data valid
- mem_data  in  DATA_W  load data
- wb_en  out  1  register file write strobe (registered)
- wb_num  out  REG_AW  write register number (registered)
- wb_data  out  DATA_W  write data (registered)
- err  out  1  one-cycle pulse when a load times out

## Operation
- An op is accepted when in_valid && in_ready.
- Decode of an accepted op, in priority order:
  - in_jump==2'b10 (jal): num = LINK_REG, data = (in_pc + PC_INC) mod 2^DATA_W. in_regdst and in_memtoreg are ignored.
  - Otherwise num = in_regdst ? in_rd_num : in_rt_num.
  - Source is memory if in_memtoreg, else in_alu.
- in_regwrite==0 (stores, branches): the op is accepted, nothing is written, and there is no memory wait.
- A write to register 0 is always suppressed (wb_en stays 0). A load targeting r0 still waits for its data.
- States:
  - IDLE: accepts ops.
  - WAIT_MEM: waiting for load data; in_ready=0.
- IDLE transitions on an accepted load (regwrite && memtoreg && not jal):
  - If mem_valid is high in the same cycle, mem_data is captured and the state stays IDLE.
  - Otherwise num is latched, the wait counter is cleared, and the state goes to WAIT_MEM.
- WAIT_MEM, each cycle:
  - If mem_valid: write mem_data to the latched num; go to IDLE.
  - Else if counter == MEM_TIMEOUT-1: pulse err, no write, go to IDLE.
  - Else: counter += 1.
  - If mem_valid and the timeout coincide, the data wins and there is no err.
- mem_valid in IDLE with no load being accepted is ignored.
- Reset (asynchronous, any state): state=IDLE, counter=0, wb_en=0, wb_num=0, wb_data=0, err=0. A load pending at reset is discarded.

## Timing
- ALU, link, or same-cycle memory source: wb_en/wb_num/wb_data are valid on the edge after acceptance (1-cycle latency).
- Delayed load: write outputs are valid on the edge after the cycle in which mem_valid is seen. in_ready returns to 1 on that same edge.
- Back-to-back non-waiting ops are accepted every cycle; wb_en may stay high continuously.
- wb_en and err are high for exactly one cycle per event. wb_num and wb_data hold their last value while wb_en=0.
- Timeout: with no mem_valid, err is high in the cycle that begins MEM_TIMEOUT edges after acceptance. in_ready is 1 in that same cycle.

## Test plan
- Reset then jal: in_pc=0x100, in_jump=2'b10, regwrite=1 -> next cycle wb_en=1, wb_num=31, wb_data=0x101. in_pc=0xFFFFFFFF -> wb_data=0.
- R-type stream: three consecutive accepts, regdst=1, alu=1,2,3, rd=8,9,10 -> wb_en high for three cycles carrying (8,1),(9,2),(10,3). Same with regdst=0, rt=4 -> wb_num=4.
- Delayed load: memtoreg=1, rt=5, mem_valid asserted 3 cycles later with data 0xDEADBEEF -> in_ready=0 during the wait, then wb_en=1, wb_num=5, wb_data=0xDEADBEEF, and in_ready=1 on the same edge.
- Timeout: load accepted, mem_valid never asserted -> err pulses once 15 cycles later, wb_en never asserts. Repeat with mem_valid arriving in the timeout cycle -> a write occurs, no err.
- r0 and non-writes: rd=0 with regdst=1 -> wb_en stays 0. Store (regwrite=0, memtoreg=1) -> accepted, in_ready stays 1, no write.
- Reset mid-wait: assert rst_n=0 asynchronously while in WAIT_MEM -> all outputs 0 immediately, in_ready=1 after release. A later stale mem_valid produces no write.
